// File: rtl/bresenham_pkg.sv
// Shared widths, state encoding and helpers for the Bresenham line stepper.
package bresenham_pkg;

  localparam int X_W_DEF = 5;  // x offset width (signed)
  localparam int Y_W_DEF = 4;  // y offset width (signed)
  localparam int ERR_W   = 8;  // decision-variable width (signed)

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    STEP  = 2'd2
  } state_e;

  // Doubling of a signed decision term; kept in one place so every err
  // update uses the same width.
  function automatic logic signed [ERR_W-1:0] twice(input logic signed [ERR_W-1:0] v);
    return v <<< 1;
  endfunction

endpackage

// File: rtl/bresenham_stepper_octant_select.sv
// Octant normalisation: magnitudes, flip flags, and major/minor axis pick.
module octant_select
  import bresenham_pkg::*;
#(
  parameter int X_W   = X_W_DEF,
  parameter int Y_W   = Y_W_DEF,
  parameter int MAG_W = 6
) (
  input  logic signed [X_W-1:0]   dx,
  input  logic signed [Y_W-1:0]   dy,
  output logic                    flip_x,
  output logic                    flip_y,
  output logic                    flip_identity,
  output logic        [MAG_W-1:0] major,
  output logic        [MAG_W-1:0] minor
);

  logic signed [MAG_W-1:0] dx_e, dy_e;
  logic        [MAG_W-1:0] ax, ay;

  // Sign-extend one bit wider than the inputs so |-16| and |-8| fit, then
  // swap axes when y dominates (a tie stays on the x-major side).
  always_comb begin
    dx_e          = MAG_W'(dx);
    dy_e          = MAG_W'(dy);
    flip_x        = dx[X_W-1];
    flip_y        = dy[Y_W-1];
    ax            = flip_x ? MAG_W'(-dx_e) : MAG_W'(dx_e);
    ay            = flip_y ? MAG_W'(-dy_e) : MAG_W'(dy_e);
    flip_identity = (ay > ax);
    major         = flip_identity ? ay : ax;
    minor         = flip_identity ? ax : ay;
  end

endmodule

// File: rtl/bresenham_stepper.sv
// First-octant Bresenham line walker with valid/ready request and point ports.
module bresenham_stepper
  import bresenham_pkg::*;
#(
  parameter int X_W = X_W_DEF,
  parameter int Y_W = Y_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic signed [X_W-1:0] dx,
  input  logic signed [Y_W-1:0] dy,
  output logic                  point_valid,
  input  logic                  point_ready,
  output logic        [X_W-1:0] x_in,
  output logic        [Y_W-1:0] y_in,
  output logic                  flip_x,
  output logic                  flip_y,
  output logic                  flip_identity,
  output logic                  point_last
);

  // One extra bit over the wider axis holds the magnitude of the most
  // negative offset without wrapping.
  localparam int MAG_W = ((X_W > Y_W) ? X_W : Y_W) + 1;

  state_e                   state_q, state_d;
  logic                     alive_q, alive_d;
  logic signed [X_W-1:0]    dx_q, dx_d;
  logic signed [Y_W-1:0]    dy_q, dy_d;
  logic                     fx_q, fx_d, fy_q, fy_d, fi_q, fi_d;
  logic        [MAG_W-1:0]  major_q, major_d, minor_q, minor_d;
  logic        [MAG_W-1:0]  x_q, x_d, y_q, y_d;
  logic signed [ERR_W-1:0]  err_q, err_d;

  logic                     oct_fx, oct_fy, oct_fi;
  logic        [MAG_W-1:0]  oct_major, oct_minor;
  logic signed [ERR_W-1:0]  major_e, minor_e, oct_major_e, oct_minor_e;
  logic                     at_last;

  octant_select #(.X_W(X_W), .Y_W(Y_W), .MAG_W(MAG_W)) u_oct (
    .dx            (dx_q),
    .dy            (dy_q),
    .flip_x        (oct_fx),
    .flip_y        (oct_fy),
    .flip_identity (oct_fi),
    .major         (oct_major),
    .minor         (oct_minor)
  );

  assign at_last     = (x_q == major_q);
  assign major_e     = {{(ERR_W-MAG_W){1'b0}}, major_q};
  assign minor_e     = {{(ERR_W-MAG_W){1'b0}}, minor_q};
  assign oct_major_e = {{(ERR_W-MAG_W){1'b0}}, oct_major};
  assign oct_minor_e = {{(ERR_W-MAG_W){1'b0}}, oct_minor};

  // State and datapath registers; synchronous reset abandons any line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      alive_q <= 1'b0;
      dx_q    <= '0;
      dy_q    <= '0;
      fx_q    <= 1'b0;
      fy_q    <= 1'b0;
      fi_q    <= 1'b0;
      major_q <= '0;
      minor_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      alive_q <= alive_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      fi_q    <= fi_d;
      major_q <= major_d;
      minor_q <= minor_d;
      x_q     <= x_d;
      y_q     <= y_d;
      err_q   <= err_d;
    end
  end

  // Next state: accept in IDLE, one setup cycle, walk until last handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_valid && start_ready) state_d = SETUP;
      SETUP:   state_d = STEP;
      STEP:    if (point_ready && at_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch request, derive octant, then advance x and the error term.
  always_comb begin
    alive_d = 1'b1;
    dx_d    = dx_q;
    dy_d    = dy_q;
    fx_d    = fx_q;
    fy_d    = fy_q;
    fi_d    = fi_q;
    major_d = major_q;
    minor_d = minor_q;
    x_d     = x_q;
    y_d     = y_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start_valid && start_ready) begin
          dx_d = dx;
          dy_d = dy;
        end
      end
      SETUP: begin
        fx_d    = oct_fx;
        fy_d    = oct_fy;
        fi_d    = oct_fi;
        major_d = oct_major;
        minor_d = oct_minor;
        x_d     = '0;
        y_d     = '0;
        err_d   = twice(oct_minor_e) - oct_major_e;
      end
      STEP: begin
        if (point_ready && !at_last) begin
          x_d = x_q + MAG_W'(1);
          if (err_q > 0) begin
            y_d   = y_q + MAG_W'(1);
            err_d = err_q + twice(minor_e - major_e);
          end else begin
            err_d = err_q + twice(minor_e);
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs: flags hold between lines; last is qualified by STEP so an idle
  // x==major match never shows up.
  always_comb begin
    start_ready   = alive_q && (state_q == IDLE);
    point_valid   = (state_q == STEP);
    point_last    = (state_q == STEP) && at_last;
    x_in          = x_q[X_W-1:0];
    y_in          = y_q[Y_W-1:0];
    flip_x        = fx_q;
    flip_y        = fy_q;
    flip_identity = fi_q;
  end

endmodule
